// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared display definitions: segment width, bit order and the active-high hex font.
// Every font entry is stored as {g,f,e,d,c,b,a}.
package display_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Entry 15 comes first in the concatenation, so FONT_TABLE[n] is the glyph for n.
    localparam logic [15:0][SEG_W-1:0] FONT_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_W-1:0] font_lookup(input logic [3:0] nibble);
        return FONT_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Host write port of the scan controller.
// The host drives new hex data and decimal points together with a one-cycle write strobe.
interface seven_seg_scan_ctrl_if #(
    parameter int N_DIGITS = 8
);

    logic [4*N_DIGITS-1:0] DATA_IN;
    logic [N_DIGITS-1:0]   DP_IN;
    logic                  DATA_WE;

    modport master (output DATA_IN, output DP_IN, output DATA_WE);
    modport slave  (input  DATA_IN, input  DP_IN, input  DATA_WE);

endinterface

// File: rtl/seven_seg_scan_ctrl_hex_to_7seg.sv
// Combinational hex-nibble to active-high segment decoder.
// Output polarity is applied by the caller.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    logic [SEG_W-1:0] glyph;

    // Font glyphs are stored a..g from bit 0 upwards; route each one to its named segment position.
    always_comb begin
        glyph      = font_lookup(nibble);
        seg        = '0;
        seg[SEG_A] = glyph[0];
        seg[SEG_B] = glyph[1];
        seg[SEG_C] = glyph[2];
        seg[SEG_D] = glyph[3];
        seg[SEG_E] = glyph[4];
        seg[SEG_F] = glyph[5];
        seg[SEG_G] = glyph[6];
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment driver with a double-buffered display register,
// leading-zero blanking, per-digit enables, decimal points and an anti-ghosting guard.
module seven_seg_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int GUARD      = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    seven_seg_scan_ctrl_if.slave  wr_bus,
    input  logic [N_DIGITS-1:0]   EN_MASK,
    input  logic                  LZB,
    output logic [N_DIGITS-1:0]   AN,
    output logic [SEG_W-1:0]      SEG,
    output logic                  DP,
    output logic                  FRAME_SYNC
);

    localparam int                   IDX_W      = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]           GUARD_LOAD = 8'(GUARD);
    localparam logic [N_DIGITS-1:0]  AN_OFF     = {N_DIGITS{ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]     SEG_OFF    = {SEG_W{ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0]  AN_ONE     = N_DIGITS'(1);

    logic [IDX_W-1:0]      idx;
    logic [7:0]            guard_cnt;
    logic                  pending;
    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [4*N_DIGITS-1:0] disp_data;
    logic [N_DIGITS-1:0]   disp_dp;

    logic                  wrap;
    logic                  commit;
    logic [N_DIGITS-1:0]   lead_zero;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  blanked;
    logic                  digit_on;
    logic [N_DIGITS-1:0]   an_sel;
    logic [SEG_W-1:0]      font_seg;

    // A frame ends when the last digit is stepped past; only then may new data reach the display.
    always_comb begin
        wrap   = CE && (idx == LAST_IDX);
        commit = wrap && pending;
    end

    // Every CE advances the digit and re-arms the guard, including a CE that arrives mid-guard.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx       <= '0;
            guard_cnt <= '0;
        end else if (CE) begin
            idx       <= wrap ? '0 : idx + 1'b1;
            guard_cnt <= GUARD_LOAD;
        end else if (guard_cnt != 8'd0) begin
            guard_cnt <= guard_cnt - 8'd1;
        end
    end

    // The commit samples the pre-edge shadow, so a write on the commit edge is kept for the next frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
            disp_data   <= '0;
            disp_dp     <= '0;
            FRAME_SYNC  <= 1'b0;
        end else begin
            if (wr_bus.DATA_WE) begin
                shadow_data <= wr_bus.DATA_IN;
                shadow_dp   <= wr_bus.DP_IN;
            end
            if (commit) begin
                disp_data <= shadow_data;
                disp_dp   <= shadow_dp;
            end
            pending    <= wr_bus.DATA_WE | (pending & ~commit);
            FRAME_SYNC <= commit;
        end
    end

    // lead_zero[i] is set when every nibble from the top digit down to digit i is zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run          = run && (disp_data[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
    end

    always_comb begin
        cur_nib  = disp_data[int'(idx)*4 +: 4];
        cur_dp   = disp_dp[idx];
        blanked  = LZB && (idx != '0) && lead_zero[idx];
        digit_on = (guard_cnt == 8'd0) && EN_MASK[idx] && !blanked;
        an_sel   = digit_on ? (AN_ONE << idx) : '0;
    end

    hex_to_7seg u_font (
        .nibble (cur_nib),
        .seg    (font_seg)
    );

    // Pins are registered; XOR with the off pattern turns active-high values into the board polarity.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AN  <= AN_OFF;
            SEG <= SEG_OFF;
            DP  <= ACTIVE_LOW;
        end else begin
            AN  <= an_sel ^ AN_OFF;
            SEG <= digit_on ? (font_seg ^ SEG_OFF) : SEG_OFF;
            DP  <= (digit_on && cur_dp) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: one instance without guard for scan/commit/blanking/reset,
// one instance with a 4-cycle guard for the dark-interval and masking behaviour.
module tb_seven_seg_scan_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CE;
    logic [7:0] EN_MASK;
    logic       LZB;

    logic [7:0] an0, an4;
    logic [6:0] seg0, seg4;
    logic       dp0, dp4, fs0, fs4;

    int vectors     = 0;
    int miscompares = 0;

    // Active-high hex font, written out by hand.
    localparam logic [6:0] FONT_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seven_seg_scan_ctrl_if #(.N_DIGITS(8)) bus ();

    seven_seg_scan_ctrl #(.N_DIGITS(8), .GUARD(0), .ACTIVE_LOW(1'b1)) dut0 (
        .CLK        (CLK),
        .RST        (RST),
        .CE         (CE),
        .wr_bus     (bus),
        .EN_MASK    (EN_MASK),
        .LZB        (LZB),
        .AN         (an0),
        .SEG        (seg0),
        .DP         (dp0),
        .FRAME_SYNC (fs0)
    );

    seven_seg_scan_ctrl #(.N_DIGITS(8), .GUARD(4), .ACTIVE_LOW(1'b1)) dut4 (
        .CLK        (CLK),
        .RST        (RST),
        .CE         (CE),
        .wr_bus     (bus),
        .EN_MASK    (EN_MASK),
        .LZB        (LZB),
        .AN         (an4),
        .SEG        (seg4),
        .DP         (dp4),
        .FRAME_SYNC (fs4)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pins(input string tag, input logic [7:0] an, input logic [6:0] seg,
                              input logic dp, input int d, input logic [3:0] nib,
                              input bit lit, input bit dp_lit);
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        exp_an  = lit ? ~(8'b1 << d) : 8'hFF;
        exp_seg = lit ? ~FONT_HI[nib] : 7'h7F;
        check($sformatf("%s an d%0d", tag, d), an, exp_an);
        check($sformatf("%s seg d%0d", tag, d), seg, exp_seg);
        check($sformatf("%s dp d%0d", tag, d), dp, (lit && dp_lit) ? 1'b0 : 1'b1);
    endtask

    task automatic show0(input int d, input logic [3:0] nib, input bit lit, input bit dp_lit, input bit fs);
        step();
        check_pins("g0", an0, seg0, dp0, d, nib, lit, dp_lit);
        check($sformatf("g0 frame_sync d%0d", d), fs0, fs);
    endtask

    task automatic post_write(input logic [31:0] data, input logic [7:0] dps);
        bus.DATA_IN = data;
        bus.DP_IN   = dps;
        bus.DATA_WE = 1'b1;
    endtask

    initial begin
        logic [3:0] a05 [8];
        bit found;
        a05 = '{4'h5, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

        RST         = 1'b1;
        CE          = 1'b0;
        LZB         = 1'b0;
        EN_MASK     = 8'hFF;
        bus.DATA_IN = '0;
        bus.DP_IN   = '0;
        bus.DATA_WE = 1'b0;
        repeat (2) step();

        check("reset an", an0, 8'hFF);
        check("reset seg", seg0, 7'h7F);
        check("reset dp", dp0, 1'b1);
        check("reset frame_sync", fs0, 1'b0);
        check("reset an guard dut", an4, 8'hFF);

        $display("[TB] scan order");
        RST = 1'b0;
        CE  = 1'b1;
        post_write(32'h7654_3210, 8'h00);
        step();
        bus.DATA_WE = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (fs0) found = 1'b1;
        end
        check("first commit seen", found, 1'b1);
        for (int d = 0; d < 8; d++) show0(d, 4'(d), 1'b1, 1'b0, 1'b0);

        $display("[TB] tear-free commit");
        for (int d = 0; d < 3; d++) show0(d, 4'(d), 1'b1, 1'b0, 1'b0);
        post_write(32'h1111_1111, 8'h00);
        show0(3, 4'd3, 1'b1, 1'b0, 1'b0);
        bus.DATA_WE = 1'b0;
        for (int d = 4; d < 7; d++) show0(d, 4'(d), 1'b1, 1'b0, 1'b0);
        post_write(32'h2222_2222, 8'h00);
        show0(7, 4'd7, 1'b1, 1'b0, 1'b1);
        bus.DATA_WE = 1'b0;
        for (int d = 0; d < 8; d++) show0(d, 4'h1, 1'b1, 1'b0, d == 7);
        for (int d = 0; d < 8; d++) show0(d, 4'h2, 1'b1, 1'b0, 1'b0);

        $display("[TB] leading-zero blanking");
        LZB = 1'b1;
        post_write(32'h0000_0A05, 8'h00);
        show0(0, 4'h2, 1'b1, 1'b0, 1'b0);
        bus.DATA_WE = 1'b0;
        for (int d = 1; d < 8; d++) show0(d, 4'h2, 1'b1, 1'b0, d == 7);
        for (int d = 0; d < 8; d++) show0(d, a05[d], d <= 2, 1'b0, 1'b0);
        LZB = 1'b0;
        post_write(32'h7654_3210, 8'h81);
        show0(0, a05[0], 1'b1, 1'b0, 1'b0);
        bus.DATA_WE = 1'b0;
        for (int d = 1; d < 8; d++) show0(d, a05[d], 1'b1, 1'b0, d == 7);

        $display("[TB] decimal points");
        for (int d = 0; d < 8; d++) show0(d, 4'(d), 1'b1, (d == 0) || (d == 7), 1'b0);

        $display("[TB] guard and masking");
        check("guard dut dark under continuous ce", an4, 8'hFF);
        CE      = 1'b0;
        EN_MASK = 8'hF0;
        repeat (6) step();
        for (int k = 1; k < 8; k++) begin
            CE = 1'b1;
            step();
            CE = 1'b0;
            for (int g = 0; g < 4; g++) begin
                step();
                check($sformatf("guard dark d%0d c%0d", k, g), an4, 8'hFF);
            end
            step();
            check_pins("g4", an4, seg4, dp4, k, 4'(k), k >= 4, k == 7);
        end

        $display("[TB] async reset mid-frame");
        CE      = 1'b1;
        EN_MASK = 8'hFF;
        post_write(32'h9999_9999, 8'hFF);
        step();
        bus.DATA_WE = 1'b0;
        repeat (5) step();
        #2;
        RST = 1'b1;
        #1;
        check("async reset an", an0, 8'hFF);
        check("async reset seg", seg0, 7'h7F);
        check("async reset dp", dp0, 1'b1);
        check("async reset frame_sync", fs0, 1'b0);
        step();
        check("held reset frame_sync", fs0, 1'b0);
        step();
        check("held reset an", an0, 8'hFF);
        RST = 1'b0;
        for (int d = 0; d < 8; d++) show0(d, 4'h0, 1'b1, 1'b0, 1'b0);
        show0(0, 4'h0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
